// File: rtl/sysbus_mem_responder.sv
// Sysbus far-end memory responder: tagged 64-byte line writes and reads with a
// programmable read latency, backed by a word-addressed internal memory.
//   state | meaning
//   IDLE  | waiting for an address beat
//   WDATA | taking 8 write data beats
//   LAT   | counting down read latency
//   RESP  | first cycle primes beat 0, then streams 8 response beats
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WDATA, LAT, RESP} state_t;

    state_t                    state;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [AW-4:0]             line;
    logic [2:0]                beat;
    logic [15:0]               lat_cnt;
    logic [AW-4:0]             req_line;

    // Dropping address bits above the memory depth gives the silent alias.
    assign req_line   = bus_req[AW+2:6];
    assign bus_reqack = reset && bus_reqcyc && (state == IDLE || state == WDATA);

    always_ff @(posedge clk) begin
        if (bus_reqack && state == WDATA)
            mem[{line, beat}] <= bus_req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            line        <= '0;
            beat        <= '0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_reqcyc) begin
                        bus_resptag <= bus_reqtag;
                        line        <= req_line;
                        beat        <= '0;
                        if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                            state <= WDATA;
                        end else if (READ_LATENCY > 0) begin
                            lat_cnt <= 16'(READ_LATENCY);
                            state   <= LAT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WDATA: begin
                    if (bus_reqcyc) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7)
                            state <= IDLE;
                    end
                end
                LAT: begin
                    if (lat_cnt == 16'd1)
                        state <= RESP;
                    lat_cnt <= lat_cnt - 16'd1;
                end
                RESP: begin
                    // The priming cycle supplies the extra cycle of the READ_LATENCY+1 delay.
                    if (!bus_respcyc) begin
                        bus_resp    <= mem[{line, beat}];
                        bus_respcyc <= 1'b1;
                    end else if (bus_respack) begin
                        if (beat == 3'd7) begin
                            bus_respcyc <= 1'b0;
                            beat        <= '0;
                            state       <= IDLE;
                        end else begin
                            beat     <= beat + 3'd1;
                            bus_resp <= mem[{line, beat + 3'd1}];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Bus-side memory responder for the Sysbus interface driven by the CPU top level (fetch and memory stages). Accepts tagged read/write requests on the request channel and returns 8-beat, 64-byte line responses on the response channel, with configurable read latency and an internal word-addressed memory. It serves as the far-end model for core simulation and as the base for the future L2/DRAM front end.

Parameters:
BUS_DATA_WIDTH, 64, data beat width in bits
BUS_TAG_WIDTH, 13, tag width in bits; bit [BUS_TAG_WIDTH-1] is WRITE(1)/READ(0)
MEM_WORDS, 4096, depth of the internal memory in 64-bit words (power of 2)
READ_LATENCY, 4, idle cycles between address accept and the first response beat (0 allowed)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
bus_reqcyc  in  1  request beat valid
bus_req  in  BUS_DATA_WIDTH  address beat (byte address), or write data beat
bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled on the address beat only
bus_reqack  out  1  request beat accepted this cycle
bus_respcyc  out  1  response beat valid
bus_resp  out  BUS_DATA_WIDTH  response data beat
bus_resptag  out  BUS_TAG_WIDTH  tag of the request being answered
bus_respack  in  1  initiator accepts the response beat this cycle

Behaviour:
- Transfer rules: a request beat transfers on an edge where bus_reqcyc&&bus_reqack. A response beat transfers on an edge where bus_respcyc&&bus_respack.
- bus_reqack is combinational: 1 iff reset==1 && bus_reqcyc==1 && state in {IDLE, WDATA}. It is 0 in every other state.
- Line index is bus_req[5:3] ignored, so lines are 64-byte aligned. Base word = (addr>>3) & ~7, then modulo MEM_WORDS (silent wrap/alias). Beat k addresses base+k, for k = 0..7.
- States: IDLE, WDATA, LAT, RESP.
- IDLE:
  - On an address transfer, capture the tag and base word.
  - If tag MSB=1, go to WDATA with beat counter=0.
  - If tag MSB=0, go to LAT with latency counter=READ_LATENCY when READ_LATENCY>0. Go straight to RESP when READ_LATENCY=0.
- WDATA:
  - Each transfer writes bus_req to mem[base+beat] and increments beat.
  - After beat 7 transfers, go to IDLE. No response is generated for writes.
  - Cycles with bus_reqcyc=0 stall with no timeout.
- LAT: decrement the counter each cycle. When it reaches 0, go to RESP with beat=0. Total latency from address-accept edge to first bus_respcyc=1 is READ_LATENCY+1 cycles.
- RESP:
  - bus_respcyc=1 (registered).
  - bus_resp=mem[base+beat]. bus_resptag=captured tag.
  - While bus_respack=0, bus_resp and bus_resptag are held stable.
  - On each transfer, beat increments and the next beat is presented the following cycle (back-to-back at 1 beat/cycle when respack is held high).
  - After the beat-7 transfer, bus_respcyc=0 on the next cycle and the state goes to IDLE.
- A request arriving during LAT or RESP is not acked. The initiator holds it, and it is accepted in IDLE at the earliest on the cycle after the final response beat.
- Reset values (reset==0 at an edge): state=IDLE, bus_respcyc=0, bus_resp=0, bus_resptag=0, counters=0.
- Reset mid-operation aborts immediately. Write beats already transferred stay in memory. Memory contents are never cleared by reset.
- Reads always return current memory contents. A line written then read returns the new data.

Test Plan:
1. Write tag 0x1000 to addr 0x1000 with beats 0x11,0x22,...,0x88 (reqcyc held high) -> reqack high on 9 consecutive cycles, no respcyc.
2. Read tag 0x0005 from addr 0x1018, READ_LATENCY=4, respack held high -> first respcyc exactly 5 cycles after the accept edge. Beats 0x11..0x88 appear in order on 8 consecutive cycles, resptag=0x0005 throughout.
3. Repeat the read with respack=0 for 3 cycles during beat 2 -> bus_resp stays 0x33 and respcyc stays 1 for all 3 cycles; beat 3 (0x44) follows the accept.
4. Assert reqcyc (new read) during LAT of a read -> reqack stays 0 until IDLE. The new read is accepted on the cycle after beat 7 transfers.
5. Write to 0x9000 with MEM_WORDS=4096, then read 0x1000 -> the 0x9000 data is returned (alias).
6. Assert reset=0 during beat 4 of a read -> the next cycle has respcyc=0 and resp/resptag=0. A subsequent read of the same line returns intact data.
